// File: rtl/aes_pkg.sv
// Shared encodings and GF(2^8) helpers for the parametrised AES encipher datapath.
// Used by aes_encipher_core_par and aes_mixcolumn_word.
package aes_pkg;

    typedef enum logic [1:0] {
        KEYLEN_128  = 2'd0,
        KEYLEN_256  = 2'd1,
        KEYLEN_192  = 2'd2,
        KEYLEN_RSVD = 2'd3
    } keylen_e;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef enum logic [1:0] {
        CTRL_IDLE = 2'd0,
        CTRL_INIT = 2'd1,
        CTRL_SBOX = 2'd2,
        CTRL_MAIN = 2'd3
    } ctrl_e;

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] b);
        return gm2(b) ^ b;
    endfunction

    // The reserved encoding deliberately falls back to the AES-128 round count.
    function automatic logic [3:0] num_rounds(input keylen_e keylen);
        case (keylen)
            KEYLEN_256: return NR_256;
            KEYLEN_192: return NR_192;
            default:    return NR_128;
        endcase
    endfunction

endpackage

// File: rtl/aes_mixcolumn_word.sv
// MixColumns applied to one 32-bit state column (row 0 byte in the MSBs).
module aes_mixcolumn_word
    import aes_pkg::*;
(
    input  logic [31:0] col,
    output logic [31:0] mixed
);

    logic [7:0] a0, a1, a2, a3;

    assign {a0, a1, a2, a3} = col;

    assign mixed = {gm2(a0) ^ gm3(a1) ^ a2      ^ a3,
                    a0      ^ gm2(a1) ^ gm3(a2) ^ a3,
                    a0      ^ a1      ^ gm2(a2) ^ gm3(a3),
                    gm3(a0) ^ a1      ^ a2      ^ gm2(a3)};

endmodule

// File: rtl/aes_encipher_core_par.sv
// Iterative AES-128/192/256 encipher datapath sharing an external SBOX_LANES-word S-box.
// Build option AES_ENC_OUTPUT_MASK_EN hides intermediate state on new_block while busy.
module aes_encipher_core_par
    import aes_pkg::*;
#(
    parameter int SBOX_LANES = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    next,
    input  logic [1:0]              keylen,
    output logic [3:0]              round,
    input  logic [127:0]            round_key,
    output logic [32*SBOX_LANES-1:0] sboxw,
    input  logic [32*SBOX_LANES-1:0] new_sboxw,
    input  logic [127:0]            block,
    output logic [127:0]            new_block,
    output logic                    ready
);

    if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4) begin : g_lanes_illegal
        $error("aes_encipher_core_par: SBOX_LANES must be 1, 2 or 4");
    end

    localparam int         SBOX_CYCLES = 4 / SBOX_LANES;
    localparam logic [1:0] SWORD_LAST  = 2'(SBOX_CYCLES - 1);

    ctrl_e                 ctrl_reg,   ctrl_nxt;
    logic [0:3][31:0]      state_reg,  state_nxt;
    logic [3:0]            round_reg,  round_nxt;
    logic [1:0]            sword_reg,  sword_nxt;
    keylen_e               keylen_reg, keylen_nxt;
    logic                  ready_reg,  ready_nxt;

    logic [0:3][31:0]      blk_words;
    logic [0:3][31:0]      rk_words;
    logic [0:3][31:0]      sr_words;
    logic [0:3][31:0]      mc_words;
    logic [0:SBOX_LANES-1][31:0] sbox_out;
    logic [0:SBOX_LANES-1][31:0] sbox_in;

    assign blk_words = block;
    assign rk_words  = round_key;
    assign sbox_in   = new_sboxw;
    assign sboxw     = sbox_out;
    assign round     = round_reg;
    assign ready     = ready_reg;

`ifdef AES_ENC_OUTPUT_MASK_EN
    assign new_block = ready_reg ? state_reg : 128'h0;
`else
    assign new_block = state_reg;
`endif

    // ShiftRows: row r of column c takes the byte from column (c + r) mod 4.
    always_comb begin
        sr_words = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_words[c][31-8*r -: 8] = state_reg[(c + r) % 4][31-8*r -: 8];
            end
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        aes_mixcolumn_word u_mix (
            .col   (sr_words[c]),
            .mixed (mc_words[c])
        );
    end

    always_comb begin
        sbox_out = '0;
        if (ctrl_reg == CTRL_SBOX) begin
            for (int j = 0; j < SBOX_LANES; j++) begin
                sbox_out[j] = state_reg[2'(int'(sword_reg) * SBOX_LANES + j)];
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets its hold value first, so no branch can infer a latch.
        ctrl_nxt   = ctrl_reg;
        state_nxt  = state_reg;
        round_nxt  = round_reg;
        sword_nxt  = sword_reg;
        keylen_nxt = keylen_reg;
        ready_nxt  = ready_reg;

        case (ctrl_reg)
            CTRL_IDLE: begin
                if (next) begin
                    state_nxt  = blk_words;
                    keylen_nxt = keylen_e'(keylen);
                    ready_nxt  = 1'b0;
                    round_nxt  = 4'd0;
                    ctrl_nxt   = CTRL_INIT;
                end
            end

            CTRL_INIT: begin
                state_nxt = state_reg ^ rk_words;
                round_nxt = 4'd1;
                sword_nxt = 2'd0;
                ctrl_nxt  = CTRL_SBOX;
            end

            CTRL_SBOX: begin
                for (int j = 0; j < SBOX_LANES; j++) begin
                    state_nxt[2'(int'(sword_reg) * SBOX_LANES + j)] = sbox_in[j];
                end
                if (sword_reg == SWORD_LAST) begin
                    sword_nxt = 2'd0;
                    ctrl_nxt  = CTRL_MAIN;
                end else begin
                    sword_nxt = sword_reg + 2'd1;
                end
            end

            CTRL_MAIN: begin
                if (round_reg == num_rounds(keylen_reg)) begin
                    state_nxt = sr_words ^ rk_words;
                    ready_nxt = 1'b1;
                    ctrl_nxt  = CTRL_IDLE;
                end else begin
                    state_nxt = mc_words ^ rk_words;
                    round_nxt = round_reg + 4'd1;
                    sword_nxt = 2'd0;
                    ctrl_nxt  = CTRL_SBOX;
                end
            end

            default: ctrl_nxt = CTRL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_reg   <= CTRL_IDLE;
            state_reg  <= '0;
            round_reg  <= 4'd0;
            sword_reg  <= 2'd0;
            keylen_reg <= KEYLEN_128;
            ready_reg  <= 1'b1;
        end else begin
            // NOTE: non-blocking so every register samples the values from before the edge.
            ctrl_reg   <= ctrl_nxt;
            state_reg  <= state_nxt;
            round_reg  <= round_nxt;
            sword_reg  <= sword_nxt;
            keylen_reg <= keylen_nxt;
            ready_reg  <= ready_nxt;
        end
    end

endmodule

// File: tb/tb_aes_encipher_core_par.sv
// Directed FIPS-197 bench for aes_encipher_core_par at SBOX_LANES = 1, 2 and 4 in parallel.
// The bench plays key memory and S-box; instance 0 (one lane) carries the detailed checks.
module tb_aes_encipher_core_par;

    localparam logic [0:255][7:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [127:0] PT      = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] R1_START = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] R2_START = 128'h89d810e8855ace682d1843d8cb128fe4;
    localparam logic [255:0] KEY_128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY_256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         next;
    logic [1:0]   keylen;
    logic [127:0] block;

    logic [3:0]   round_a [3];
    logic [127:0] nb_a    [3];
    logic         rdy_a   [3];
    logic [127:0] sw_a    [3];
    logic [127:0] rk_mem  [16];

    int           n_checks = 0;
    int           n_pass   = 0;
    int           lat      [3];
    logic [127:0] nb_trace [100];
    logic [3:0]   rnd_trace[100];
    logic         busy_nonzero;

    always #5 clk = ~clk;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = SBOX_TAB[w[8*b +: 8]];
        return r;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int L = 1 << k;
        logic [32*L-1:0] sw, nsw;
        logic [127:0]    rk;

        assign rk      = rk_mem[round_a[k]];
        assign sw_a[k] = 128'(sw);

        always_comb begin
            nsw = '0;
            for (int j = 0; j < L; j++) nsw[32*j +: 32] = sub_word(sw[32*j +: 32]);
        end

        aes_encipher_core_par #(.SBOX_LANES(L)) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .next      (next),
            .keylen    (keylen),
            .round     (round_a[k]),
            .round_key (rk),
            .sboxw     (sw),
            .new_sboxw (nsw),
            .block     (block),
            .new_block (nb_a[k]),
            .ready     (rdy_a[k])
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Key memory contents: standard FIPS-197 key expansion for Nk = 4/6/8.
    task automatic load_key(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (8'h1b & {8{rc[7]}});
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= nr) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk_mem[r] = '0;
        end
    endtask

    // Returns at the first falling edge after the accepting rising edge.
    task automatic start_run(input logic [1:0] kl, input logic [127:0] pt);
        @(negedge clk);
        block  = pt;
        keylen = kl;
        next   = 1'b1;
        @(negedge clk);
        next   = 1'b0;
    endtask

    task automatic wait_runs(input string tag, input int poke_at);
        bit done [3];
        int i;
        done = '{0, 0, 0};
        lat  = '{0, 0, 0};
        busy_nonzero = 1'b0;
        i = 0;
        while (!(done[0] && done[1] && done[2]) && i < 300) begin
            if (i < 100) begin
                nb_trace[i]  = nb_a[0];
                rnd_trace[i] = round_a[0];
            end
            for (int k = 0; k < 3; k++) begin
                if (!done[k]) begin
                    if (rdy_a[k]) done[k] = 1'b1;
                    else          lat[k]++;
                end
            end
            if (!rdy_a[0] && nb_a[0] != 128'h0) busy_nonzero = 1'b1;
            if (i == poke_at) begin
                next   = 1'b1;
                block  = ~block;
                keylen = 2'd1;
            end
            if (i == poke_at + 1) next = 1'b0;
            @(negedge clk);
            i++;
        end
        check({tag, " completes"}, 128'(done[0] & done[1] & done[2]), 128'd1);
    endtask

    task automatic wait_all_idle(input string tag);
        int i;
        i = 0;
        while (!(rdy_a[0] && rdy_a[1] && rdy_a[2]) && i < 300) begin
            @(negedge clk);
            i++;
        end
        check({tag, " idle"}, 128'(rdy_a[0] & rdy_a[1] & rdy_a[2]), 128'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        bit  sweep_ok;

        reset_n = 1'b0;
        next    = 1'b0;
        keylen  = 2'd0;
        block   = '0;
        for (int r = 0; r < 16; r++) rk_mem[r] = '0;

        repeat (2) @(negedge clk);
        check("reset ready", 128'(rdy_a[0]), 128'd1);
        check("reset round", 128'(round_a[0]), 128'd0);
        check("reset new_block", nb_a[0], 128'h0);
        check("reset sboxw", sw_a[0], 128'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // FIPS-197 C.1 on all three lane widths.
        load_key(KEY_128, 4);
        start_run(2'd0, PT);
        wait_runs("c1", -1);
        check("c1 ct L1", nb_a[0], CT_128);
        check("c1 ct L2", nb_a[1], CT_128);
        check("c1 ct L4", nb_a[2], CT_128);
        check("c1 latency L1", 128'(lat[0]), 128'd51);
        check("c1 latency L2", 128'(lat[1]), 128'd31);
        check("c1 latency L4", 128'(lat[2]), 128'd21);
        check("c1 round held", 128'(round_a[0]), 128'd10);
`ifdef AES_ENC_OUTPUT_MASK_EN
        check("mask busy output", 128'(busy_nonzero), 128'd0);
`else
        check("visible round1 start", nb_trace[1], R1_START);
        check("visible round2 start", nb_trace[6], R2_START);
        check("round at first sbox", 128'(rnd_trace[1]), 128'd1);
        check("round at second sbox", 128'(rnd_trace[6]), 128'd2);
`endif

        // FIPS-197 C.2 with the round counter sweep.
        load_key(KEY_192, 6);
        start_run(2'd2, PT);
        wait_runs("c2", -1);
        check("c2 ct L1", nb_a[0], CT_192);
        check("c2 ct L4", nb_a[2], CT_192);
        check("c2 latency L1", 128'(lat[0]), 128'd61);
        sweep_ok = (rnd_trace[0] == 4'd0);
        for (int i = 1; i < lat[0] && i < 100; i++) begin
            if (rnd_trace[i] != rnd_trace[i-1] && rnd_trace[i] != rnd_trace[i-1] + 4'd1)
                sweep_ok = 1'b0;
        end
        if (rnd_trace[lat[0]-1] != 4'd12) sweep_ok = 1'b0;
        check("c2 round sweep", 128'(sweep_ok), 128'd1);
        check("c2 round held", 128'(round_a[0]), 128'd12);

        // FIPS-197 C.3.
        load_key(KEY_256, 8);
        start_run(2'd1, PT);
        wait_runs("c3", -1);
        check("c3 ct L1", nb_a[0], CT_256);
        check("c3 ct L2", nb_a[1], CT_256);
        check("c3 latency L1", 128'(lat[0]), 128'd71);
        check("c3 latency L4", 128'(lat[2]), 128'd29);
        check("c3 round held", 128'(round_a[0]), 128'd14);

        // Reserved keylen runs as AES-128.
        load_key(KEY_128, 4);
        start_run(2'd3, PT);
        wait_runs("rsvd", -1);
        check("rsvd keylen ct", nb_a[0], CT_128);
        check("rsvd keylen latency", 128'(lat[0]), 128'd51);

        // next pulse plus block/keylen change mid-run: ignored.
        start_run(2'd0, PT);
        wait_runs("poke", 10);
        check("poke ct", nb_a[0], CT_128);
        check("poke latency", 128'(lat[0]), 128'd51);
        repeat (5) @(negedge clk);
        check("poke no second run", 128'(rdy_a[0]), 128'd1);
        check("poke result held", nb_a[0], CT_128);

        // next held high: back-to-back runs with one idle cycle.
        @(negedge clk);
        block  = PT;
        keylen = 2'd0;
        next   = 1'b1;
        @(negedge clk);
        cnt = 0;
        while (!rdy_a[0] && cnt < 300) begin
            cnt++;
            @(negedge clk);
        end
        check("b2b latency 1", 128'(cnt), 128'd51);
        check("b2b ct 1", nb_a[0], CT_128);
        @(negedge clk);
        check("b2b reaccept", 128'(rdy_a[0]), 128'd0);
        next = 1'b0;
        cnt = 0;
        while (!rdy_a[0] && cnt < 300) begin
            cnt++;
            @(negedge clk);
        end
        check("b2b latency 2", 128'(cnt), 128'd51);
        check("b2b ct 2", nb_a[0], CT_128);
        wait_all_idle("b2b");

        // Asynchronous reset in the round-5 SBOX cycle.
        start_run(2'd0, PT);
        cnt = 0;
        while (round_a[0] != 4'd5 && cnt < 300) begin
            cnt++;
            @(negedge clk);
        end
        check("reach round 5", 128'(round_a[0]), 128'd5);
        check("round 5 busy", 128'(rdy_a[0]), 128'd0);
        reset_n = 1'b0;
        #1;
        check("midrun reset ready", 128'(rdy_a[0]), 128'd1);
        check("midrun reset round", 128'(round_a[0]), 128'd0);
        check("midrun reset new_block", nb_a[0], 128'h0);
        check("midrun reset sboxw", sw_a[0], 128'h0);
        @(negedge clk);
        reset_n = 1'b1;
        start_run(2'd0, PT);
        wait_runs("post reset", -1);
        check("post reset ct", nb_a[0], CT_128);
        check("post reset latency", 128'(lat[0]), 128'd51);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
